axi4lite_sram_model: RTL and testbench

//  Single-port-array AXI4-Lite slave SRAM model; sole memory of the core package in simulation.

---
 rtl/axi4lite_sram_model.sv | 175 +++++++++++++++++
 tb/tb_axi4lite_sram_model.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4lite_sram_model.sv
// axi4lite_sram_model
//   AXI4-Lite slave backed by a single word array `mem` (32-bit words, index =
//   byte address >> 2, upper bits alias modulo DEPTH_WORDS). `mem` is never
//   reset, so benches may preload it hierarchically.
//
//   Ports:
//     clock, reset            rising-edge clock, synchronous active-high reset
//     aw*  (valid/ready/addr) write address; awprot/awcache ignored
//     w*   (valid/ready/data/strb) write data with byte enables
//     b*   (valid/ready/resp) write response
//     ar*  (valid/ready/addr) read address; arprot/arcache ignored
//     r*   (valid/ready/resp/data) read data, one-cycle latency
//
//   Optional feature macro: AXI_SRAM_RANGE_CHECK_EN
//     When defined, byte addresses >= 4*DEPTH_WORDS answer SLVERR (2'b10),
//     writes to them are dropped and reads return zero. When undefined,
//     such addresses alias into the array and always answer OKAY.
module axi4lite_sram_model #(
    parameter int unsigned DEPTH_WORDS = 32768,
    parameter int unsigned IDX_W       = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic [2:0]  awprot,
    input  logic [3:0]  awcache,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    input  logic [2:0]  arprot,
    input  logic [3:0]  arcache,
    output logic        rvalid,
    input  logic        rready,
    output logic [1:0]  rresp,
    output logic [31:0] rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    logic             aw_full_q, aw_full_d;
    logic [IDX_W-1:0] aw_idx_q,  aw_idx_d;
    logic             aw_oor_q,  aw_oor_d;
    logic             w_full_q,  w_full_d;
    logic [31:0]      w_data_q,  w_data_d;
    logic [3:0]       w_strb_q,  w_strb_d;
    logic             bvalid_q,  bvalid_d;
    logic [1:0]       bresp_q,   bresp_d;
    logic             rvalid_q,  rvalid_d;
    logic [1:0]       rresp_q,   rresp_d;
    logic [31:0]      rdata_q,   rdata_d;

    logic aw_hs, w_hs, ar_hs, commit;
    logic aw_oor_in, ar_oor_in;
    logic unused_ok;

`ifdef AXI_SRAM_RANGE_CHECK_EN
    assign aw_oor_in = |awaddr[31:IDX_W+2];
    assign ar_oor_in = |araddr[31:IDX_W+2];
`else
    assign aw_oor_in = 1'b0;
    assign ar_oor_in = 1'b0;
`endif

    assign unused_ok = ^{awprot, awcache, arprot, arcache, awaddr[1:0], araddr[1:0],
                         awaddr[31:IDX_W+2], araddr[31:IDX_W+2]};

    assign awready = ~aw_full_q & ~reset;
    assign wready  = ~w_full_q & ~reset;
    assign arready = ~reset & (~rvalid_q | rready);
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign rvalid  = rvalid_q;
    assign rresp   = rresp_q;
    assign rdata   = rdata_q;

    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid & wready;
    assign ar_hs = arvalid & arready;
    // A pending response that is being accepted this edge frees the B slot,
    // so the next commit can land on the same edge.
    assign commit = aw_full_q & w_full_q & (~bvalid_q | bready) & ~reset;

    always_comb begin
        aw_full_d = aw_full_q;
        aw_idx_d  = aw_idx_q;
        aw_oor_d  = aw_oor_q;
        w_full_d  = w_full_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;

        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_idx_d  = awaddr[IDX_W+1:2];
            aw_oor_d  = aw_oor_in;
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = wdata;
            w_strb_d = wstrb;
        end

        if (bvalid_q && bready) begin
            bvalid_d = 1'b0;
        end
        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = aw_oor_q ? 2'b10 : 2'b00;
        end

        if (rvalid_q && rready) begin
            rvalid_d = 1'b0;
        end
        // mem is read before this edge's commit lands, giving read-before-write.
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = ar_oor_in ? '0 : mem[araddr[IDX_W+1:2]];
            rresp_d  = ar_oor_in ? 2'b10 : 2'b00;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            aw_full_q <= 1'b0;
            aw_idx_q  <= '0;
            aw_oor_q  <= 1'b0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
        end else begin
            aw_full_q <= aw_full_d;
            aw_idx_q  <= aw_idx_d;
            aw_oor_q  <= aw_oor_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end

    always_ff @(posedge clock) begin
        if (commit && !aw_oor_q) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (w_strb_q[b]) begin
                    mem[aw_idx_q][8*b +: 8] <= w_data_q[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_axi4lite_sram_model.sv
// tb_axi4lite_sram_model
//   Directed plus randomized bench for axi4lite_sram_model. Keeps a word-level
//   reference memory (associative array keyed by aliased word index) and
//   compares every response against it.
module tb_axi4lite_sram_model;

    localparam int unsigned DEPTH = 32768;
    localparam logic [31:0] LIMIT = 32'(4 * DEPTH);

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        awvalid = 1'b0, awready;
    logic [31:0] awaddr = '0;
    logic [2:0]  awprot = '0;
    logic [3:0]  awcache = '0;
    logic        wvalid = 1'b0, wready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        bvalid, bready = 1'b1;
    logic [1:0]  bresp;
    logic        arvalid = 1'b0, arready;
    logic [31:0] araddr = '0;
    logic [2:0]  arprot = '0;
    logic [3:0]  arcache = '0;
    logic        rvalid, rready = 1'b1;
    logic [1:0]  rresp;
    logic [31:0] rdata;

    int tests = 0;
    int fails = 0;
    logic [31:0] model [int unsigned];

    always #5 clock = ~clock;

    axi4lite_sram_model #(.DEPTH_WORDS(DEPTH), .IDX_W(15)) dut (
        .clock(clock), .reset(reset),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot), .awcache(awcache),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot), .arcache(arcache),
        .rvalid(rvalid), .rready(rready), .rresp(rresp), .rdata(rdata)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        tests++;
        fails++;
        $error("FAIL %s: observed timeout expected handshake", tag);
    endtask

    function automatic bit is_oor(input logic [31:0] a);
`ifdef AXI_SRAM_RANGE_CHECK_EN
        return a >= LIMIT;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int unsigned widx(input logic [31:0] a);
        return (a / 4) % DEPTH;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        if (is_oor(a)) return;
        w = model.exists(widx(a)) ? model[widx(a)] : 32'h0;
        for (int i = 0; i < 4; i++)
            if (s[i]) w[8*i +: 8] = d[8*i +: 8];
        model[widx(a)] = w;
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (is_oor(a)) return 32'h0;
        return model.exists(widx(a)) ? model[widx(a)] : 32'h0;
    endfunction

    // lead = number of cycles W is presented before AW (0: same cycle)
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int unsigned lead, input string tag);
        int unsigned c = 0;
        int unsigned lat = 0;
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        awaddr = a; wdata = d; wstrb = s; wvalid = 1'b1; awvalid = (lead == 0);
        while (!(aw_done && w_done) && c < 50) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            tick();
            c++;
            if (aw_hs) begin awvalid = 1'b0; aw_done = 1; end
            if (w_hs)  begin wvalid = 1'b0;  w_done = 1;  end
            if (!aw_done && c >= lead) awvalid = 1'b1;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        if (!(aw_done && w_done)) begin
            timeout({tag, " aw/w"});
            return;
        end
        chk({tag, " bvalid early"}, 32'(bvalid), 32'd0);
        while (!bvalid && lat < 20) begin tick(); lat++; end
        if (!bvalid) begin
            timeout({tag, " b"});
            return;
        end
        chk({tag, " b latency"}, lat, 32'd1);
        chk({tag, " bresp"}, 32'(bresp), is_oor(a) ? 32'd2 : 32'd0);
        tick();
        chk({tag, " single b"}, 32'(bvalid), 32'd0);
        model_write(a, d, s);
    endtask

    task automatic axi_read(input logic [31:0] a, input string tag, output logic [31:0] got);
        int unsigned c = 0;
        bit hs = 0;
        logic [31:0] exp;
        exp = model_read(a);
        got = 'x;
        araddr = a; arvalid = 1'b1;
        while (!hs && c < 50) begin
            hs = arready;
            tick();
            c++;
        end
        arvalid = 1'b0;
        if (!hs) begin
            timeout({tag, " ar"});
            return;
        end
        chk({tag, " rvalid"}, 32'(rvalid), 32'd1);
        chk({tag, " rdata"}, rdata, exp);
        chk({tag, " rresp"}, 32'(rresp), is_oor(a) ? 32'd2 : 32'd0);
        got = rdata;
        tick();
        chk({tag, " rvalid drop"}, 32'(rvalid), 32'd0);
    endtask

    initial begin
        logic [31:0] got, da, db, a;
        int unsigned c;

        // ---- reset, preload, reset survival, mid-transaction drop ----
        reset = 1'b1;
        repeat (5) tick();
        chk("reset readies", {29'd0, awready, wready, arready}, 32'd0);
        reset = 1'b0;
        #1;
        chk("readies after reset", {29'd0, awready, wready, arready}, 32'd7);

        for (int i = 0; i < 64; i++)
            axi_write(32'h7000 + 32'(4 * i), $urandom, 4'hF, 0, "init");
        axi_write(32'h4100, $urandom, 4'hF, 0, "preload");

        // W accepted alone, then reset must discard it
        wdata = 32'h5A5A5A5A; wstrb = 4'hF; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("readies in reset", {29'd0, awready, wready, arready}, 32'd0);
            chk("b/r valid in reset", {30'd0, bvalid, rvalid}, 32'd0);
        end
        chk("resp/rdata in reset", {bresp, rresp, rdata[27:0]}, 32'd0);
        reset = 1'b0;
        tick();
        chk("no stray b after reset", 32'(bvalid), 32'd0);
        axi_read(32'h4100, "survive", got);
        axi_write(32'h7014, 32'h0BADCAFE, 4'hF, 0, "post-reset wr");
        axi_read(32'h7014, "post-reset rd", got);
        chk("post-reset value", got, 32'h0BADCAFE);

        // ---- basic write/read ----
        axi_write(32'h6000, 32'h00000001, 4'hF, 0, "tohost wr");
        axi_read(32'h6000, "tohost rd", got);
        chk("tohost value", got, 32'h00000001);

        // ---- byte strobes ----
        axi_write(32'h7000, 32'hDEADBEEF, 4'hF, 0, "strb pre");
        axi_write(32'h7000, 32'h11223344, 4'b0101, 1, "strb wr");
        axi_read(32'h7000, "strb rd", got);
        chk("strb value", got, 32'hDE22BE44);
        axi_write(32'h7030, 32'hFFFFFFFF, 4'h0, 0, "strb0 wr");
        axi_read(32'h7030, "strb0 rd", got);

        // ---- W three cycles ahead of AW ----
        axi_write(32'h4100, 32'hCAFEF00D, 4'hF, 3, "w first");
        axi_read(32'h4100, "w first rd", got);
        chk("w first value", got, 32'hCAFEF00D);

        // ---- B backpressure with a second write pending ----
        da = $urandom; db = $urandom;
        bready = 1'b0;
        awaddr = 32'h7020; wdata = da; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        chk("bp A ready", {30'd0, awready, wready}, 32'd3);
        tick();
        awaddr = 32'h7024; wdata = db;
        chk("bp holding full", 32'(awready), 32'd0);
        tick();
        chk("bp A bvalid", 32'(bvalid), 32'd1);
        model_write(32'h7020, da, 4'hF);
        chk("bp B ready", {30'd0, awready, wready}, 32'd3);
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp bvalid held", 32'(bvalid), 32'd1);
            chk("bp bresp held", 32'(bresp), 32'd0);
            chk("bp no second commit", 32'(awready), 32'd0);
        end
        axi_read(32'h7024, "bp old B", got);
        axi_read(32'h7020, "bp A", got);
        bready = 1'b1;
        tick();
        c = 0;
        while (!bvalid && c < 20) begin tick(); c++; end
        if (!bvalid) timeout("bp B response");
        else begin
            tick();
            chk("bp B single", 32'(bvalid), 32'd0);
        end
        model_write(32'h7024, db, 4'hF);
        axi_read(32'h7024, "bp new B", got);

        // ---- R backpressure ----
        rready = 1'b0;
        araddr = 32'h7028; arvalid = 1'b1;
        chk("rbp arready", 32'(arready), 32'd1);
        tick();
        araddr = 32'h702C;
        for (int i = 0; i < 4; i++) begin
            chk("rbp rvalid held", 32'(rvalid), 32'd1);
            chk("rbp rdata held", rdata, model_read(32'h7028));
            chk("rbp arready low", 32'(arready), 32'd0);
            tick();
        end
        rready = 1'b1;
        #1;
        chk("rbp arready release", 32'(arready), 32'd1);
        tick();
        arvalid = 1'b0;
        chk("rbp second rvalid", 32'(rvalid), 32'd1);
        chk("rbp second rdata", rdata, model_read(32'h702C));
        tick();
        chk("rbp drain", 32'(rvalid), 32'd0);

        // ---- streaming reads ----
        for (int i = 1; i < 4; i++)
            axi_write(32'h4100 + 32'(4 * i), $urandom, 4'hF, 0, "stream init");
        arvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            araddr = 32'h4100 + 32'(4 * i);
            chk("stream arready", 32'(arready), 32'd1);
            tick();
            chk("stream rvalid", 32'(rvalid), 32'd1);
            chk("stream rdata", rdata, model_read(32'h4100 + 32'(4 * i)));
        end
        arvalid = 1'b0;
        tick();
        chk("stream end", 32'(rvalid), 32'd0);

        // ---- out-of-range / aliasing ----
        axi_write(32'h0000, $urandom, 4'hF, 0, "word0 init");
        axi_write(32'h0004, $urandom, 4'hF, 0, "word1 init");
        axi_read(LIMIT, "oor rd", got);
        axi_write(LIMIT + 32'h4, $urandom, 4'hF, 2, "oor wr");
        axi_read(32'h0004, "oor alias check", got);

        // ---- randomized traffic in the data region ----
        for (int i = 0; i < 40; i++) begin
            a = 32'h7000 + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0)
                axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 2), "rand wr");
            else
                axi_read(a, "rand rd", got);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
